// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stall, branch flush, E-stage
// forwarding selects, a data-memory wait/timeout FSM and saturating performance counters.
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             ResultSrcE,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WCNT_W-1:0] r_wait_cnt;
   logic              r_mem_err;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;

   logic              w_mem_stall;
   logic              w_lw_stall;
   logic              w_freeze;

   assign w_mem_stall = MemReqM & ~MemReadyM;
   assign w_lw_stall  = ResultSrcE & (RdE != 5'd0) & ((Rs1D == RdE) | (Rs2D == RdE));

   // State register plus the wait counter, error flag and performance counters.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_RUN;
         r_wait_cnt  <= '0;
         r_mem_err   <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_RUN)
            r_wait_cnt <= '0;
         else if (r_state == S_WAIT)
            r_wait_cnt <= r_wait_cnt + 1'b1;
         if (w_state_nxt == S_ERR)
            r_mem_err <= 1'b1;
         if ((StallF | StallD | StallM) && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (FlushD && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN:  if (w_mem_stall) w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (MemReadyM)
               w_state_nxt = S_RUN;
            else if (r_wait_cnt == WCNT_LAST)
               w_state_nxt = S_ERR;
         end
         S_ERR:  w_state_nxt = S_ERR;
         default: w_state_nxt = S_RUN;
      endcase
   end

   // Freeze overrides branch flushes; a held PCSrcE is applied once the freeze lifts.
   always_comb begin
      w_freeze = w_mem_stall | (r_state == S_ERR);
      StallF   = w_lw_stall;
      StallD   = w_lw_stall;
      StallE   = 1'b0;
      StallM   = 1'b0;
      FlushD   = PCSrcE;
      FlushE   = w_lw_stall | PCSrcE;
      FlushW   = 1'b0;
      if (w_freeze) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushD = 1'b0;
         FlushE = 1'b0;
         FlushW = 1'b1;
      end
   end

   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
         ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
         ForwardAE = 2'b01;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
         ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
         ForwardBE = 2'b01;
   end

   assign MemErr   = r_mem_err;
   assign StallCnt = r_stall_cnt;
   assign FlushCnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with TIMEOUT=4 and CNT_W=4 so timeout
// and counter saturation are reachable in a few cycles.
module tb_pipeline_hazard_ctrl;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic             RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM;
   logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
   logic [1:0]       ForwardAE, ForwardBE;
   logic [CNT_W-1:0] StallCnt, FlushCnt;

   int n_checks = 0;
   int n_fails  = 0;

   pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
      .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
      RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
      RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 1'b0;
      PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic check_frozen(input string tag);
      check({tag, ".stalls"}, {28'd0, StallF, StallD, StallE, StallM}, 32'hF);
      check({tag, ".flushW"}, {31'd0, FlushW}, 32'd1);
      check({tag, ".flushDE"}, {30'd0, FlushD, FlushE}, 32'd0);
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      #2;
      do_reset();

      // Reset state
      check("rst.stalls", {28'd0, StallF, StallD, StallE, StallM}, 32'd0);
      check("rst.flushes", {29'd0, FlushD, FlushE, FlushW}, 32'd0);
      check("rst.memerr", {31'd0, MemErr}, 32'd0);
      check("rst.stallcnt", {28'd0, StallCnt}, 32'd0);
      check("rst.flushcnt", {28'd0, FlushCnt}, 32'd0);

      // Load-use on rs1, then rs2, then RdE = x0
      ResultSrcE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd9;
      #1;
      check("lu.stallFD", {30'd0, StallF, StallD}, 32'h3);
      check("lu.flushE", {31'd0, FlushE}, 32'd1);
      check("lu.flushD", {31'd0, FlushD}, 32'd0);
      check("lu.stallEM", {30'd0, StallE, StallM}, 32'd0);
      step();
      check("lu.stallcnt1", {28'd0, StallCnt}, 32'd1);
      Rs1D = 5'd1; Rs2D = 5'd5;
      #1;
      check("lu.rs2", {30'd0, StallF, FlushE}, 32'h3);
      RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
      #1;
      check("lu.x0", {29'd0, StallF, StallD, FlushE}, 32'd0);
      step();
      check("lu.x0cnt", {28'd0, StallCnt}, 32'd1);
      ResultSrcE = 1'b0; RdE = 5'd5; Rs1D = 5'd5;
      #1;
      check("lu.noload", {30'd0, StallF, FlushE}, 32'd0);
      idle_inputs();

      // Forwarding priority and x0
      RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7; Rs2E = 5'd7;
      #1;
      check("fwd.A_M", {30'd0, ForwardAE}, 32'd2);
      check("fwd.B_M", {30'd0, ForwardBE}, 32'd2);
      RdM = 5'd3;
      #1;
      check("fwd.A_W", {30'd0, ForwardAE}, 32'd1);
      Rs2E = 5'd3;
      #1;
      check("fwd.B_M2", {30'd0, ForwardBE}, 32'd2);
      RegWriteM = 1'b0;
      #1;
      check("fwd.B_noWM", {30'd0, ForwardBE}, 32'd0);
      RdW = 5'd0; Rs1E = 5'd0;
      #1;
      check("fwd.A_x0", {30'd0, ForwardAE}, 32'd0);
      idle_inputs();

      // Branch held during a 3-cycle memory wait
      do_reset();
      PCSrcE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_frozen($sformatf("bw.cyc%0d", i));
         step();
      end
      MemReadyM = 1'b1;
      #1;
      check("bw.release", {28'd0, FlushD, FlushE, StallF, StallM}, 32'hC);
      check("bw.flushW", {31'd0, FlushW}, 32'd0);
      step();
      check("bw.flushcnt", {28'd0, FlushCnt}, 32'd1);
      check("bw.stallcnt", {28'd0, StallCnt}, 32'd3);
      idle_inputs();

      // Timeout: one RUN cycle plus TIMEOUT wait cycles, then ERR
      do_reset();
      MemReqM = 1'b1; MemReadyM = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) step();
      check("to.noerr_yet", {31'd0, MemErr}, 32'd0);
      step();
      check("to.memerr", {31'd0, MemErr}, 32'd1);
      MemReqM = 1'b0; MemReadyM = 1'b1;
      step();
      check_frozen("to.err");
      check("to.memerr_hold", {31'd0, MemErr}, 32'd1);
      do_reset();
      check("to.rst_memerr", {31'd0, MemErr}, 32'd0);
      check("to.rst_run", {28'd0, StallF, StallD, StallE, StallM}, 32'd0);
      idle_inputs();

      // Saturation of the 4-bit stall counter
      do_reset();
      ResultSrcE = 1'b1; RdE = 5'd4; Rs2D = 5'd4;
      for (int i = 0; i < 20; i++) step();
      check("sat.stallcnt", {28'd0, StallCnt}, 32'd15);
      idle_inputs();

      // Reset during the second wait cycle
      do_reset();
      MemReqM = 1'b1; MemReadyM = 1'b0;
      step();
      step();
      MemReqM = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("rw.stallcnt", {28'd0, StallCnt}, 32'd0);
      check("rw.stalls", {28'd0, StallF, StallD, StallE, StallM}, 32'd0);
      for (int i = 0; i < TIMEOUT + 2; i++) step();
      check("rw.still_run", {28'd0, StallF, StallD, StallE, StallM}, 32'd0);
      check("rw.no_err", {31'd0, MemErr}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage pipeline (F/D/E/M/W).
- Combines the following functions:
  - load-use stall detection;
  - branch/jump flush;
  - E-stage operand forwarding selects;
  - a data-memory wait FSM that freezes the pipeline while the memory is not ready and reports a timeout.
- Also keeps saturating performance counters for stall cycles and flush events.
- Sits beside the decoder and pipeline registers. Drives their enable and clear inputs.

Parameters:
- TIMEOUT, 16: maximum consecutive wait cycles before a memory timeout error is raised (must be >= 1).
- CNT_W, 32: width of the performance counters.

Ports:
- clk, input, 1: pipeline clock.
- rst, input, 1: synchronous reset, active-high.
- Rs1D, input, 5: rs1 field of the D-stage instruction.
- Rs2D, input, 5: rs2 field of the D-stage instruction.
- Rs1E, input, 5: rs1 field of the E-stage instruction.
- Rs2E, input, 5: rs2 field of the E-stage instruction.
- RdE, input, 5: destination register, E stage.
- RdM, input, 5: destination register, M stage.
- RdW, input, 5: destination register, W stage.
- RegWriteM, input, 1: M-stage instruction writes the register file.
- RegWriteW, input, 1: W-stage instruction writes the register file.
- ResultSrcE, input, 1: E-stage instruction is a load.
- PCSrcE, input, 1: branch taken or jump, resolved in E.
- MemReqM, input, 1: M-stage instruction accesses data memory.
- MemReadyM, input, 1: data memory completes the access this cycle.
- StallF, output, 1: hold the PC.
- StallD, output, 1: hold the IF/ID register.
- StallE, output, 1: hold the ID/EX register.
- StallM, output, 1: hold the EX/MEM register.
- FlushD, output, 1: clear IF/ID.
- FlushE, output, 1: clear ID/EX.
- FlushW, output, 1: insert a bubble into MEM/WB.
- ForwardAE, output, 2: SrcA select. 00 = register file, 01 = W-stage result, 10 = M-stage ALU result.
- ForwardBE, output, 2: SrcB select, same encoding as ForwardAE.
- MemErr, output, 1: sticky memory-timeout error.
- StallCnt, output, CNT_W: count of stall cycles.
- FlushCnt, output, CNT_W: count of branch-flush events.

Behaviour:
- FSM states: RUN, WAIT, ERR. Reset state is RUN.
- Reset: internal wait counter = 0, MemErr = 0, StallCnt = 0, FlushCnt = 0.
- memStall = MemReqM & ~MemReadyM, evaluated in RUN and in WAIT.
- Transitions:
  - RUN -> WAIT when memStall.
  - WAIT -> RUN when MemReadyM.
  - WAIT -> ERR when the wait counter reaches TIMEOUT-1 and MemReadyM = 0.
  - ERR is left only by rst.
- Wait counter: cleared on entering WAIT, increments by 1 each WAIT cycle.
- MemErr is set on entry to ERR and holds until rst.
- Freeze (memStall asserted, or state = ERR):
  - StallF = StallD = StallE = StallM = 1, FlushW = 1.
  - FlushD = 0, FlushE = 0. A pending PCSrcE is held in E and applied on the first unfrozen cycle.
- Load-use stall: lwStall = ResultSrcE & (RdE != 0) & ((Rs1D == RdE) | (Rs2D == RdE)). Applies only when not frozen.
- Normal (not frozen) outputs:
  - StallF = StallD = lwStall.
  - StallE = StallM = 0, FlushW = 0.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
- If lwStall and PCSrcE occur together, both sets of signals assert. The flush discards the stalled instruction; no special-casing.
- Forwarding (ForwardAE; ForwardBE is identical using Rs2E):
  - 10 if RegWriteM & (RdM != 0) & (RdM == Rs1E);
  - else 01 if RegWriteW & (RdW != 0) & (RdW == Rs1E);
  - else 00.
  - M has priority over W. Register x0 never forwards. Forwarding is computed regardless of freeze.
- All hazard and forwarding outputs are combinational from inputs and the registered state, so their latency is 0 cycles.
- StallCnt increments by 1 in every cycle where any of StallF, StallD or StallM is 1.
- FlushCnt increments by 1 in every cycle where FlushD is 1.
- Both counters saturate at 2^CNT_W - 1; no wrap.
- rst asserted mid-WAIT or in ERR: next cycle state = RUN, all counters and MemErr cleared. Outputs follow the inputs combinationally.

Test Plan:
1. Load-use: ResultSrcE = 1, RdE = 5, Rs1D = 5 -> StallF = StallD = FlushE = 1, FlushD = 0. StallCnt increments by 1. With RdE = 0 instead -> no stall.
2. Forwarding priority: RegWriteM = RegWriteW = 1, RdM = RdW = Rs1E = 7 -> ForwardAE = 10. Set RdM = 3 -> ForwardAE = 01. Set RdW = 0 and Rs1E = 0 -> ForwardAE = 00.
3. Branch during memory wait: PCSrcE = 1, MemReqM = 1, MemReadyM = 0 for 3 cycles -> all four stalls and FlushW = 1 for 3 cycles, FlushD = 0. On the cycle MemReadyM = 1 -> FlushD = FlushE = 1, FlushCnt = 1, StallCnt = 3.
4. Timeout: TIMEOUT = 4, MemReqM = 1, MemReadyM held at 0 -> ERR entered after the 4th wait cycle. MemErr = 1 and all stalls remain 1 after MemReadyM later rises. rst -> MemErr = 0, state = RUN.
5. Saturation: CNT_W = 4, 20 consecutive load-use stall cycles -> StallCnt stops at 15.
6. Reset mid-WAIT: rst pulsed during cycle 2 of a wait with MemReqM deasserted -> StallCnt = 0 and state = RUN on the next cycle, all stalls 0.
